pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32 pipeline (F,D,E,M,W).
//  Merges hazard-unit requests (load-use stall, branch flush) with multi-cycle
//  sources: data-memory wait in M, instruction-memory wait in F, and iterative
//  mul/div occupying E. Drives per-stage stall enables and flushes, and tracks
//  a memory-wait watchdog and a stall-cycle perf counter.
// PARAMETERS
//  MD_LAT   4     mul/div occupancy in cycles; legal range 1..15
//  TIMEOUT  255   consecutive D-mem wait cycles before MemTimeout; 1..255
// PORTS
//  clk          in   1   pipeline clock
//  reset_n      in   1   asynchronous, active-low reset
//  HzStallF     in   1   hazard unit: load-use stall of F
//  HzStallD     in   1   hazard unit: load-use stall of D
//  HzFlushD     in   1   hazard unit: branch/jump flush of D
//  HzFlushE     in   1   hazard unit: load-use bubble or branch flush of E
//  IMemReadyF   in   1   instruction fetch data valid this cycle
//  MemReqM      in   1   load/store in M
//  DMemReadyM   in   1   data memory completes M access this cycle
//  MdValidE     in   1   mul/div instruction in E
//  StallF/D/E/M out  1   hold the corresponding stage register
//  FlushD/E/M/W out  1   load a bubble into the corresponding stage register
//  MdDoneE      out  1   1-cycle pulse: mul/div result valid, E advances
//  MdBusy       out  1   state == MD_BUSY
//  MemTimeout   out  1   sticky D-mem watchdog error
//  StallCycles  out  32  cycles with StallF=1; wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (reset_n=0, async): state=RUN, md_cnt=0, wait_cnt=0, MemTimeout=0,
//   StallCycles=0, MdDoneE=0, MdBusy=0; all Stall*=0, all Flush*=1 while low.
//  Freeze sources, highest priority first (combinational from state/inputs):
//   1 memwait = MemReqM & ~DMemReadyM: StallF/D/E/M=1, FlushW=1; all other
//     requests suppressed (they re-assert from held stage state next cycle).
//   2 mdwait = (RUN & MdValidE & ~md_served) | (MD_BUSY & ~md_release):
//     StallF/D/E=1, FlushM=1; hazard/branch requests suppressed.
//   3 hazard: StallF=HzStallF, StallD=HzStallD, FlushD=HzFlushD,
//     FlushE=HzFlushE, passed through unmodified.
//   4 imemwait = ~IMemReadyF: StallF=1, FlushD=1, OR-merged with level 3.
//     HzFlushD set together with imemwait: FlushD=1, StallF=1; PC redirect
//     is applied by the PC mux, not by this block.
//  FSM (2 states):
//   RUN: MdValidE & ~md_served & ~memwait -> MD_BUSY, md_cnt<=MD_LAT-1.
//   MD_BUSY: md_cnt decrements to 0 and saturates there.
//    md_release = (md_cnt==0) & ~memwait; on md_release: MdDoneE=1, StallE=0,
//    go RUN, set md_served. E-instr freezes exactly MD_LAT cycles if
//    undisturbed; memwait during MD_BUSY extends the freeze, never shortens.
//   md_served clears the first cycle E is not stalled after release, so
//    back-to-back mul/div each get a full MD_LAT stall.
//  Watchdog: wait_cnt (8b) ++ each memwait cycle, cleared when memwait=0;
//   reaching TIMEOUT sets MemTimeout=1 until reset. Stalls unchanged.
//  StallCycles increments on every cycle with StallF=1, any source.
//  Reset mid-operation: MD_BUSY is abandoned; no MdDoneE is issued.
// TESTING
//  T1 HzStallF=HzStallD=HzFlushE=1 for 1 cycle, no other source
//     -> StallF/D=1, FlushE=1 for that cycle; StallCycles +1.
//  T2 MdValidE held, MD_LAT=4 -> StallF/D/E=1, FlushM=1 for 4 cycles;
//     MdDoneE=1 in cycle 5; two back-to-back mul/divs -> 4+4 stall cycles.
//  T3 MemReqM=1, DMemReadyM=0 for 3 cycles during MD_BUSY at md_cnt=1
//     -> StallF..M=1, FlushW=1; MdDoneE is delayed to the cycle after the wait.
//  T4 HzFlushD=HzFlushE=1 together with memwait -> FlushD/E=0,
//     StallF..M=1; the branch flush appears once DMemReadyM=1.
//  T5 DMemReadyM=0 held, TIMEOUT=255 -> MemTimeout rises on wait cycle 255
//     and stays 1 after DMemReadyM=1; clears only on reset_n=0.
//  T6 reset_n low mid-MD_BUSY (md_cnt=2) -> async: Stall*=0, Flush*=1,
//     MdBusy=0; after release, RUN with no MdDoneE pulse.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32 pipeline (F,D,E,M,W).
// Merges hazard-unit requests with multi-cycle freeze sources and produces the
// per-stage stall/flush controls, a mul/div handshake, a D-mem watchdog and a
// stall-cycle performance counter.
//
// Freeze sources, highest priority first:
//   D-mem wait in M, mul/div occupying E, hazard unit, I-mem wait in F.
//
// Ports:
//   clk, reset_n (async, active-low)
//   HzStallF/HzStallD/HzFlushD/HzFlushE : hazard-unit requests
//   IMemReadyF                          : fetch data valid
//   MemReqM, DMemReadyM                 : load/store in M and its completion
//   MdValidE                            : mul/div instruction in E
//   StallF/D/E/M, FlushD/E/M/W          : stage-register hold / bubble controls
//   MdDoneE                             : mul/div result valid, E advances
//   MdBusy                              : iterative mul/div in progress
//   MemTimeout                          : sticky D-mem watchdog error
//   StallCycles                         : count of cycles with StallF=1
module pipeline_ctrl #(
  parameter int unsigned MD_LAT  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        HzStallF,
  input  logic        HzStallD,
  input  logic        HzFlushD,
  input  logic        HzFlushE,
  input  logic        IMemReadyF,
  input  logic        MemReqM,
  input  logic        DMemReadyM,
  input  logic        MdValidE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        FlushW,
  output logic        MdDoneE,
  output logic        MdBusy,
  output logic        MemTimeout,
  output logic [31:0] StallCycles
);

  typedef enum logic {RUN, MD_BUSY} state_e;

  localparam logic [3:0] MD_INIT   = 4'(MD_LAT - 1);
  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic        md_served_q, md_served_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic memwait, imemwait, md_release, mdwait;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;

  // Freeze-source decode
  always_comb begin
    memwait    = MemReqM & ~DMemReadyM;
    imemwait   = ~IMemReadyF;
    md_release = (state_q == MD_BUSY) & (md_cnt_q == '0) & ~memwait;
    mdwait     = ((state_q == RUN) & MdValidE & ~md_served_q) |
                 ((state_q == MD_BUSY) & ~md_release);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      RUN: begin
        if (MdValidE & ~md_served_q & ~memwait) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_INIT;
        end
      end
      MD_BUSY: begin
        // Counter keeps running under memwait; release waits for memwait to end.
        if (md_cnt_q != '0) md_cnt_d = md_cnt_q - 4'd1;
        if (md_release)     state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Output logic: priority merge of freeze sources
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (memwait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (mdwait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else begin
      stall_f = HzStallF | imemwait;
      stall_d = HzStallD;
      flush_d = HzFlushD | imemwait;
      flush_e = HzFlushE;
    end

    // Reset forces every stage to hold a bubble, independent of the clock.
    StallF      = reset_n & stall_f;
    StallD      = reset_n & stall_d;
    StallE      = reset_n & stall_e;
    StallM      = reset_n & stall_m;
    FlushD      = ~reset_n | flush_d;
    FlushE      = ~reset_n | flush_e;
    FlushM      = ~reset_n | flush_m;
    FlushW      = ~reset_n | flush_w;
    MdDoneE     = reset_n & md_release;
    MdBusy      = reset_n & (state_q == MD_BUSY);
    MemTimeout  = mem_timeout_q;
    StallCycles = stall_cycles_q;
  end

  // Watchdog, served flag and perf counter
  always_comb begin
    // Served only survives while E stays held; E advances on release,
    // so a following mul/div always gets its own full occupancy.
    md_served_d    = (md_served_q | md_release) & stall_e;
    wait_cnt_d     = '0;
    if (memwait) wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 8'd1;
    mem_timeout_d  = mem_timeout_q |
                     (memwait & (({1'b0, wait_cnt_q} + 9'd1) >= TIMEOUT_W));
    stall_cycles_d = stall_f ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_served_q    <= 1'b0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      md_served_q    <= md_served_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int unsigned MD_LAT  = 4;
  localparam int unsigned TIMEOUT = 255;

  // Input vector order: {HzStallF,HzStallD,HzFlushD,HzFlushE,IMemReadyF,MemReqM,DMemReadyM,MdValidE}
  localparam logic [7:0] IDLE = 8'b0000_1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic HzStallF = 1'b0, HzStallD = 1'b0, HzFlushD = 1'b0, HzFlushE = 1'b0;
  logic IMemReadyF = 1'b1, MemReqM = 1'b0, DMemReadyM = 1'b1, MdValidE = 1'b0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic MdDoneE, MdBusy, MemTimeout;
  logic [31:0] StallCycles;

  pipeline_ctrl #(.MD_LAT(MD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .HzStallF(HzStallF), .HzStallD(HzStallD), .HzFlushD(HzFlushD), .HzFlushE(HzFlushE),
    .IMemReadyF(IMemReadyF), .MemReqM(MemReqM), .DMemReadyM(DMemReadyM), .MdValidE(MdValidE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .MdDoneE(MdDoneE), .MdBusy(MdBusy), .MemTimeout(MemTimeout), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  // Expected flags: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,MdDoneE,MdBusy,MemTimeout}
  typedef struct packed {
    logic [10:0] flags;
    logic [31:0] cyc;
    logic [7:0]  stim;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: mul/div tracked as "cycles frozen so far", watchdog as a
  // run length of wait cycles, perf counter as a plain tally.
  bit          m_active;
  int unsigned m_elapsed;
  int unsigned m_waitrun;
  bit          m_timeout;
  logic [31:0] m_stallcyc;

  task automatic model_reset();
    m_active   = 0;
    m_elapsed  = 0;
    m_waitrun  = 0;
    m_timeout  = 0;
    m_stallcyc = '0;
  endtask

  task automatic step(input logic [7:0] v);
    exp_t e;
    bit hsf, hsd, hfd, hfe, imr, mreq, mrdy, mdv;
    bit memwait, mdwait, rel, sf, sd, se, sm, fd, fe, fm, fw;
    {hsf, hsd, hfd, hfe, imr, mreq, mrdy, mdv} = v;
    {HzStallF, HzStallD, HzFlushD, HzFlushE, IMemReadyF, MemReqM, DMemReadyM, MdValidE} = v;
    memwait = mreq && !mrdy;
    rel     = m_active && (m_elapsed >= MD_LAT) && !memwait;
    mdwait  = m_active ? !rel : mdv;
    {sf, sd, se, sm, fd, fe, fm, fw} = '0;
    if (memwait) begin
      sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
    end else if (mdwait) begin
      sf = 1; sd = 1; se = 1; fm = 1;
    end else begin
      sf = hsf | !imr; sd = hsd; fd = hfd | !imr; fe = hfe;
    end
    e.flags = {sf, sd, se, sm, fd, fe, fm, fw, rel, m_active, m_timeout};
    e.cyc   = m_stallcyc;
    e.stim  = v;
    exp_q.push_back(e);
    if (m_active) begin
      if (rel) m_active = 0;
      else     m_elapsed++;
    end else if (mdv && !memwait) begin
      m_active  = 1;
      m_elapsed = 1;
    end
    m_waitrun = memwait ? m_waitrun + 1 : 0;
    if (m_waitrun >= TIMEOUT) m_timeout = 1;
    if (sf) m_stallcyc = m_stallcyc + 32'd1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int ncyc, input logic [7:0] v);
    exp_t e;
    reset_n = 1'b0;
    {HzStallF, HzStallD, HzFlushD, HzFlushE, IMemReadyF, MemReqM, DMemReadyM, MdValidE} = v;
    model_reset();
    for (int i = 0; i < ncyc; i++) begin
      e.flags = 11'b0000_1111_000;
      e.cyc   = '0;
      e.stim  = v;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
  endtask

  task automatic repeat_step(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) step(v);
  endtask

  // Monitor: compares DUT outputs mid-cycle against queued expectations.
  always @(negedge clk) begin
    exp_t e;
    logic [10:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
             MdDoneE, MdBusy, MemTimeout};
      checks++;
      if (act !== e.flags) begin
        errors++;
        $display("FAIL flags t=%0t stim=%b act=%b exp=%b", $time, e.stim, act, e.flags);
      end
      checks++;
      if (StallCycles !== e.cyc) begin
        errors++;
        $display("FAIL stall_cycles t=%0t act=%0d exp=%0d", $time, StallCycles, e.cyc);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset(2, IDLE);

    // T1: load-use hazard for one cycle
    step(8'b1101_1000);
    repeat_step(2, IDLE);

    // T2: back-to-back mul/div with MdValidE held
    repeat_step(10, 8'b0000_1001);
    repeat_step(2, IDLE);

    // T3: memwait for 3 cycles while mul/div has one cycle left
    repeat_step(3, 8'b0000_1001);
    repeat_step(3, 8'b0000_1101);
    step(8'b0000_1111);
    repeat_step(2, IDLE);

    // T4: branch flush under memwait, then released
    repeat_step(2, 8'b0011_1100);
    step(8'b0011_1110);
    repeat_step(2, IDLE);

    // I-mem wait alone and combined with a branch flush
    repeat_step(2, 8'b0000_0000);
    step(8'b0010_0000);
    step(IDLE);

    // T5: watchdog
    repeat_step(TIMEOUT + 3, 8'b0000_1100);
    repeat_step(3, 8'b0000_1110);
    do_reset(1, IDLE);
    repeat_step(2, IDLE);

    // T6: reset mid mul/div
    repeat_step(3, 8'b0000_1001);
    do_reset(2, 8'b0000_1001);
    repeat_step(3, IDLE);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      v[3] = ($urandom_range(0, 7) != 0);
      v[2] = ($urandom_range(0, 2) == 0);
      v[1] = ($urandom_range(0, 2) != 0);
      v[0] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) v[7:4] = '0;
      if ($urandom_range(0, 199) == 0) do_reset(1, v);
      else step(v);
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
